music_sequencer: RTL and testbench
==================================

Name: music_sequencer

Overview:
- Beat sequencer and tone player for the arcade's background music.
- Drives the shared beat index into both song tone tables (Entertainer, 1/4 time, beats 1..160; Morning Mood, 3/4 time, beats 1..120) and selects the active table's tone.
- Converts the selected tone frequency into a square-wave audio output with a phase accumulator.
- Sits between the game FSM (play/stop/song select) and the Basys3 audio pin.

Parameters:
- CLK_HZ, 100000000, system clock frequency in Hz; phase-accumulator modulus.
- TICKS_ENT, 12500000, clock cycles per beat for song 0 (Entertainer).
- TICKS_AM, 25000000, clock cycles per beat for song 1 (Morning Mood).
- LAST_ENT, 160, final beat index of song 0.
- LAST_AM, 120, final beat index of song 1.
- SIL_HZ, 20000, tone values >= this are treated as silence.
- GAP_TICKS, 1250000, articulation gap length in cycles (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- play  in  1  level-sampled request: start, or restart, the selected song.
- stop  in  1  abort playback.
- song_sel  in  1  0 = Entertainer, 1 = Morning Mood; sampled only when play is accepted.
- loop_en  in  1  1 = wrap to beat 1 after the last beat; 0 = stop after the last beat.
- tone_ent  in  32  tone from the song-0 table, addressed by beat_num.
- tone_am  in  32  tone from the song-1 table, addressed by beat_num.
- beat_num  out  8  beat index driven to both tone tables.
- tone  out  32  selected tone in Hz; SIL_HZ while not playing.
- audio  out  1  square wave at tone Hz; 0 when silent.
- playing  out  1  high in PLAY.
- song_done  out  1  one-cycle pulse at the end of the last beat.

Behaviour:
Reset values (async):
- State IDLE.
- beat_num = 0, tone = SIL_HZ, audio = 0, playing = 0, song_done = 0.
- song register = 0, tick counter = 0, phase accumulator = 0.

States: IDLE and PLAY.
- IDLE: on play=1 and stop=0:
  - latch song_sel;
  - beat_num <= 1, tick <= 0;
  - go to PLAY; playing = 1 on the next cycle.
- PLAY:
  - tick increments each cycle.
  - When tick == TICKS_sel-1: tick <= 0, and beat_num either advances by 1 or wraps/ends as below.
  - TICKS_sel and LAST_sel come from the latched song.
- End of the last beat (beat_num == LAST_sel and tick == TICKS_sel-1):
  - song_done = 1 for that single cycle.
  - If loop_en = 1: beat_num <= 1, stay in PLAY.
  - If loop_en = 0: beat_num <= 0, go to IDLE.
  - loop_en is sampled at that same cycle.

Priority and simultaneous events:
- stop=1 in any state: next cycle is IDLE with beat_num = 0, tick = 0, and accumulator and audio cleared.
- stop beats play when both are asserted; stop also suppresses song_done in that cycle.
- play=1 while in PLAY restarts the song: re-latch song_sel, beat_num <= 1, tick <= 0. No song_done pulse is produced, even on the last tick.
- song_sel changes during PLAY without play are ignored.

Tone selection:
- tone is registered: tone <= (latched song ? tone_am : tone_ent) when in PLAY, else SIL_HZ.
- So tone lags beat_num by exactly 1 cycle; the tables are combinational.

Audio generation:
- Accumulator is 33 bits unsigned; inc = 2*tone.
- Each cycle while tone < SIL_HZ and tone != 0:
  - if acc + inc >= CLK_HZ: acc <= acc + inc - CLK_HZ and toggle audio;
  - else acc <= acc + inc.
- When tone >= SIL_HZ or tone == 0: acc <= 0 and audio <= 0.
- The accumulator is not reset on note change, for phase continuity.

Optional Feature:
- Macro MUSIC_ARTIC_GAP_EN.
- Defined: during the last GAP_TICKS cycles of every beat (tick >= TICKS_sel-GAP_TICKS), tone is forced to SIL_HZ. This separates repeated notes (e.g. consecutive C5 beats).
  - GAP_TICKS must be < TICKS_ENT and < TICKS_AM.
- Not defined: tone follows the table for the whole beat; GAP_TICKS is unused.

Test Plan:
All scenarios use TICKS_ENT=4, TICKS_AM=6, LAST_ENT=3, LAST_AM=2, CLK_HZ=1000.
1. Reset mid-PLAY (rst pulsed asynchronously between edges) -> beat_num=0, tone=20000, audio=0, playing=0 immediately. No activity until play.
2. play=1 for 1 cycle, song_sel=0, loop_en=0 -> beat_num 1,2,3 each held 4 cycles. song_done pulses on the 12th PLAY cycle, then beat_num=0 and playing=0.
3. song_sel=1, loop_en=1, play -> beats 1,2 held 6 cycles each, then wrap to 1. song_done pulses every 12 cycles. Toggling song_sel mid-play has no effect.
4. play and stop asserted together in PLAY -> IDLE next cycle, beat_num=0, no song_done. play during beat 3 alone -> beat_num=1, tick=0, no song_done.
5. Force tone_ent=100 constant, play -> audio toggles every 5 cycles (period 10 cycles = 100 Hz at CLK_HZ=1000). tone_ent=20000 -> audio held 0.
6. With MUSIC_ARTIC_GAP_EN and GAP_TICKS=1 -> tone=20000 on the last cycle of every beat (registered, 1-cycle lag). Without the macro, tone equals the table value throughout the beat.

Source files
------------

// File: rtl/music_sequencer.sv
// Beat sequencer and square-wave tone player for the background music.
// Optional articulation gap before each beat boundary: define MUSIC_ARTIC_GAP_EN.
module music_sequencer #(
   parameter int unsigned CLK_HZ    = 100000000,
   parameter int unsigned TICKS_ENT = 12500000,
   parameter int unsigned TICKS_AM  = 25000000,
   parameter int unsigned LAST_ENT  = 160,
   parameter int unsigned LAST_AM   = 120,
   parameter int unsigned SIL_HZ    = 20000,
   parameter int unsigned GAP_TICKS = 1250000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        play,
   input  logic        stop,
   input  logic        song_sel,
   input  logic        loop_en,
   input  logic [31:0] tone_ent,
   input  logic [31:0] tone_am,
   output logic [7:0]  beat_num,
   output logic [31:0] tone,
   output logic        audio,
   output logic        playing,
   output logic        song_done
);

   typedef enum logic {IDLE, PLAY} state_t;

`ifdef MUSIC_ARTIC_GAP_EN
   localparam bit GAP_EN = 1'b1;
`else
   localparam bit GAP_EN = 1'b0;
`endif

   localparam logic [31:0] SIL_W = 32'(SIL_HZ);
   localparam logic [33:0] CLK_W = 34'(CLK_HZ);

   state_t      state;
   logic        song;
   logic [31:0] tick;
   logic [32:0] acc;

   logic [31:0] ticks_sel;
   logic [7:0]  last_sel;
   logic        tick_end;
   logic        tone_gap;
   logic        silent;
   logic [33:0] acc_sum;

   always_comb begin
      ticks_sel = song ? 32'(TICKS_AM) : 32'(TICKS_ENT);
      last_sel  = song ? 8'(LAST_AM) : 8'(LAST_ENT);
      tick_end  = (tick == ticks_sel - 32'd1);
      tone_gap  = GAP_EN && (tick >= ticks_sel - 32'(GAP_TICKS));
      silent    = (tone >= SIL_W) || (tone == '0);
      acc_sum   = {1'b0, acc} + {1'b0, tone, 1'b0};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         song      <= 1'b0;
         tick      <= '0;
         beat_num  <= '0;
         tone      <= SIL_W;
         acc       <= '0;
         audio     <= 1'b0;
         playing   <= 1'b0;
         song_done <= 1'b0;
      end else begin
         song_done <= 1'b0;

         // stop outranks play; play outranks normal beat advance (restart, no done pulse)
         if (stop) begin
            state    <= IDLE;
            playing  <= 1'b0;
            beat_num <= '0;
            tick     <= '0;
         end else if (play) begin
            state    <= PLAY;
            playing  <= 1'b1;
            song     <= song_sel;
            beat_num <= 8'd1;
            tick     <= '0;
         end else begin
            case (state)
               IDLE: ;
               PLAY: begin
                  if (tick_end) begin
                     tick <= '0;
                     if (beat_num == last_sel) begin
                        song_done <= 1'b1;
                        if (loop_en) begin
                           beat_num <= 8'd1;
                        end else begin
                           beat_num <= '0;
                           state    <= IDLE;
                           playing  <= 1'b0;
                        end
                     end else begin
                        beat_num <= beat_num + 8'd1;
                     end
                  end else begin
                     tick <= tick + 32'd1;
                  end
               end
               default: state <= IDLE;
            endcase
         end

         if (!stop && state == PLAY && !tone_gap)
            tone <= song ? tone_am : tone_ent;
         else
            tone <= SIL_W;

         // accumulator survives note changes so pitch transitions stay phase-continuous
         if (stop || silent) begin
            acc   <= '0;
            audio <= 1'b0;
         end else if (acc_sum >= CLK_W) begin
            acc   <= 33'(acc_sum - CLK_W);
            audio <= ~audio;
         end else begin
            acc   <= acc_sum[32:0];
         end
      end
   end

endmodule

// File: tb/tb_music_sequencer.sv
// Scoreboard bench for music_sequencer: a position-based song model predicts outputs per cycle.
module tb_music_sequencer;

   localparam int unsigned CLK_HZ = 1000;
   localparam int unsigned T_ENT  = 4;
   localparam int unsigned T_AM   = 6;
   localparam int unsigned L_ENT  = 3;
   localparam int unsigned L_AM   = 2;
   localparam int unsigned SIL    = 20000;
   localparam int unsigned GAP    = 1;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        play = 1'b0, stop = 1'b0, song_sel = 1'b0, loop_en = 1'b0;
   logic [31:0] tone_ent, tone_am;
   logic [7:0]  beat_num;
   logic [31:0] tone;
   logic        audio, playing, song_done;

   int unsigned ent_tab [0:255];
   int unsigned am_tab  [0:255];
   bit          force_en = 1'b0;
   int unsigned force_val = 0;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int unsigned beat;
      int unsigned tone;
      bit          audio;
      bit          playing;
      bit          done;
   } exp_t;
   exp_t q[$];

   // behavioural model: song position in cycles since (re)start
   bit          m_play, m_song, m_audio, m_done;
   int unsigned m_pos, m_beat, m_tone, m_acc;

   music_sequencer #(
      .CLK_HZ(CLK_HZ), .TICKS_ENT(T_ENT), .TICKS_AM(T_AM),
      .LAST_ENT(L_ENT), .LAST_AM(L_AM), .SIL_HZ(SIL), .GAP_TICKS(GAP)
   ) dut (
      .clk(clk), .rst(rst), .play(play), .stop(stop), .song_sel(song_sel),
      .loop_en(loop_en), .tone_ent(tone_ent), .tone_am(tone_am),
      .beat_num(beat_num), .tone(tone), .audio(audio), .playing(playing),
      .song_done(song_done)
   );

   always #5 clk = ~clk;

   always_comb begin
      tone_ent = force_en ? force_val : ent_tab[beat_num];
      tone_am  = am_tab[beat_num];
   end

   function automatic int unsigned lookup(bit s, int unsigned b);
      if (s) return am_tab[b];
      if (force_en) return force_val;
      return ent_tab[b];
   endfunction

   task automatic model_reset();
      m_play = 0; m_song = 0; m_audio = 0; m_done = 0;
      m_pos = 0; m_beat = 0; m_tone = SIL; m_acc = 0;
   endtask

   function automatic exp_t snap();
      exp_t e;
      e.beat = m_beat; e.tone = m_tone; e.audio = m_audio;
      e.playing = m_play; e.done = m_done;
      return e;
   endfunction

   task automatic model_step();
      int unsigned ticks, last, otone;
      bit gap;
      ticks = m_song ? T_AM : T_ENT;
      last  = m_song ? L_AM : L_ENT;
      otone = m_tone;
`ifdef MUSIC_ARTIC_GAP_EN
      gap = (m_pos % ticks) >= ticks - GAP;
`else
      gap = 0;
`endif
      m_tone = (!stop && m_play && !gap) ? lookup(m_song, m_beat) : SIL;

      if (stop || otone >= SIL || otone == 0) begin
         m_acc = 0; m_audio = 0;
      end else begin
         m_acc += 2 * otone;
         if (m_acc >= CLK_HZ) begin
            m_acc -= CLK_HZ; m_audio = !m_audio;
         end
      end

      m_done = 0;
      if (stop) begin
         m_play = 0; m_beat = 0; m_pos = 0;
      end else if (play) begin
         m_play = 1; m_song = song_sel; m_pos = 0; m_beat = 1;
      end else if (m_play) begin
         if (m_pos == ticks * last - 1) begin
            m_done = 1; m_pos = 0;
            if (loop_en) m_beat = 1;
            else begin m_play = 0; m_beat = 0; end
         end else begin
            m_pos++;
            m_beat = m_pos / ticks + 1;
         end
      end
   endtask

   initial forever begin
      @(posedge clk);
      if (rst) model_reset();
      else model_step();
      q.push_back(snap());
   end

   task automatic chk(string n, int unsigned a, int unsigned e);
      checks++;
      if (a != e) begin
         errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", n, $time, a, e);
      end
   endtask

   initial forever begin
      exp_t e;
      @(negedge clk);
      if (q.size() > 0) begin
         e = q.pop_front();
         chk("beat_num", beat_num, e.beat);
         chk("tone", tone, e.tone);
         chk("audio", audio, e.audio);
         chk("playing", playing, e.playing);
         chk("song_done", song_done, e.done);
      end
   end

   task automatic drive(bit p, bit s, bit ss, bit l, int n);
      play = p; stop = s; song_sel = ss; loop_en = l;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic async_reset();
      #2;
      rst = 1'b1;
      model_reset();
      q.delete();
      q.push_back(snap());
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         ent_tab[i] = ($urandom_range(0, 7) == 0) ? 25000 : $urandom_range(60, 450);
         am_tab[i]  = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(60, 450);
      end
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      drive(0, 0, 0, 0, 3);

      // single Entertainer pass, no loop
      drive(1, 0, 0, 0, 1);
      drive(0, 0, 0, 0, 16);

      // Morning Mood looping, song_sel wiggled mid-play
      drive(1, 0, 1, 1, 1);
      for (int i = 0; i < 30; i++) drive(0, 0, i[0], 1, 1);

      // play+stop together, then restart during beat 3
      drive(1, 1, 0, 1, 1);
      drive(0, 0, 0, 1, 2);
      drive(1, 0, 0, 1, 1);
      drive(0, 0, 0, 1, 9);
      drive(1, 0, 0, 1, 1);
      drive(0, 0, 0, 1, 6);

      // asynchronous reset between edges mid-song
      async_reset();
      drive(0, 0, 0, 0, 4);

      // constant tone: 100 Hz and silent tone
      force_en = 1'b1; force_val = 100;
      drive(1, 0, 0, 1, 1);
      drive(0, 0, 0, 1, 40);
      force_val = 20000;
      drive(0, 0, 0, 1, 10);
      force_en = 1'b0;
      drive(0, 1, 0, 0, 1);

      // randomized control traffic
      for (int i = 0; i < 400; i++)
         drive($urandom_range(0, 19) == 0, $urandom_range(0, 39) == 0,
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), 1);

      drive(0, 0, 0, 0, 3);
      @(negedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
